// File: rtl/pen_16to4.sv
// rtl/pen_16to4.sv - 16-to-4 priority encoder, w[15] highest, registered y/z.
// Optional multi-hot err output under PEN16TO4_MULTIHOT_EN.
module pen_16to4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] w,
  output logic [3:0]  y,
  output logic        z
`ifdef PEN16TO4_MULTIHOT_EN
  ,
  output logic        err
`endif
);

  logic [3:0] y_d, y_q;
  logic       z_d, z_q;

  // Ascending scan so the highest set bit overwrites any lower one.
  always_comb begin
    y_d = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w[i]) y_d = 4'(i);
    end
    z_d = |w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 4'd0;
      z_q <= 1'b0;
    end else begin
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign y = y_q;
  assign z = z_q;

`ifdef PEN16TO4_MULTIHOT_EN
  logic err_d, err_q;

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign err_d = |(w & (w - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_pen_16to4.sv
// tb/tb_pen_16to4.sv - directed self-checking bench for pen_16to4.
// Covers err when PEN16TO4_MULTIHOT_EN is defined.
module tb_pen_16to4;

  logic        clk;
  logic        rst_n;
  logic [15:0] w;
  logic [3:0]  y;
  logic        z;
`ifdef PEN16TO4_MULTIHOT_EN
  logic        err;
`endif

  int tests;
  int fails;

  pen_16to4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .w     (w),
    .y     (y),
    .z     (z)
`ifdef PEN16TO4_MULTIHOT_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_yz(input string tag, input logic [3:0] ey, input logic ez);
    tests++;
    assert (y === ey) else begin
      fails++;
      $error("FAIL %s y: got %0d expected %0d", tag, y, ey);
    end
    tests++;
    assert (z === ez) else begin
      fails++;
      $error("FAIL %s z: got %0b expected %0b", tag, z, ez);
    end
  endtask

  task automatic chk_err(input string tag, input logic eerr);
`ifdef PEN16TO4_MULTIHOT_EN
    tests++;
    assert (err === eerr) else begin
      fails++;
      $error("FAIL %s err: got %0b expected %0b", tag, err, eerr);
    end
`endif
  endtask

  // Drive w at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [15:0] wv);
    @(negedge clk);
    w = wv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    w     = 16'h8000;

    #1;
    chk_yz("reset_initial", 4'd0, 1'b0);
    chk_err("reset_initial", 1'b0);
    @(posedge clk);
    #1;
    chk_yz("reset_held_over_edge", 4'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_yz("first_edge_after_reset", 4'd15, 1'b1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_yz("async_reset_midrun", 4'd0, 1'b0);
    chk_err("async_reset_midrun", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 15; i >= 0; i--) begin
      step(16'h0001 << i);
      chk_yz($sformatf("walk_%0d", i), 4'(i), 1'b1);
      chk_err($sformatf("walk_%0d", i), 1'b0);
    end

    step(16'h0000);
    chk_yz("zero_input", 4'd0, 1'b0);
    chk_err("zero_input", 1'b0);
    step(16'h0001);
    chk_yz("bit0_after_zero", 4'd0, 1'b1);

    step(16'hFFFF);
    chk_yz("prio_ffff", 4'd15, 1'b1);
    chk_err("prio_ffff", 1'b1);
    step(16'h0A01);
    chk_yz("prio_0a01", 4'd11, 1'b1);
    chk_err("prio_0a01", 1'b1);
    step(16'h0003);
    chk_yz("prio_0003", 4'd1, 1'b1);
    chk_err("prio_0003", 1'b1);
    step(16'h0400);
    chk_yz("single_0400", 4'd10, 1'b1);
    chk_err("single_0400", 1'b0);

    for (int k = 0; k < 4; k++) begin
      step(16'h0100);
      chk_yz($sformatf("alt_on_%0d", k), 4'd8, 1'b1);
      step(16'h0000);
      chk_yz($sformatf("alt_off_%0d", k), 4'd0, 1'b0);
    end

    // Outputs must not follow w before the next rising edge.
    @(negedge clk);
    w = 16'h2000;
    #1;
    chk_yz("no_comb_path", 4'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_yz("latency_one", 4'd13, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
